// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a circular-buffer FIFO feeding a shift FSM.
// Frames go out LSB-first at UART_BAUD and run back-to-back while bytes remain.
module uart_tx_fifo #(
    parameter int CLOCK_HZ  = 27_000_000,
    parameter int UART_BAUD = 115_200,
    parameter int DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [7:0]             wr_data,
    input  logic                   clr_ovr,
    output logic                   tx,
    output logic                   full,
    output logic                   empty,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun
);

    localparam int DIV = CLOCK_HZ / UART_BAUD;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_TOP = BW'(DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx_fifo: CLOCK_HZ / UART_BAUD must be at least 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_nxt;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_nxt;
    logic [7:0]    shreg;
    logic [7:0]    sh_nxt;
    logic          tx_nxt;

    // A write is judged against the pre-edge full flag, so a pop in the same cycle cannot rescue it.
    assign push = wr && !full;
    assign busy = (state != IDLE);

    // Occupancy after this edge: simultaneous push and pop cancel out.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // FIFO storage: data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and flags; all flags are registered alongside the pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
            // A dropped write wins over a clear arriving in the same cycle.
            if (wr && full) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Shifter control registers; reset forces the line high and aborts any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            tx       <= tx_nxt;
        end
    end

    // Shift register holds the frame payload only, so it carries no reset.
    always_ff @(posedge clk) begin
        shreg <= sh_nxt;
    end

    // Next-state logic: bit periods end when baud_cnt reaches zero; STOP chains straight into START.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        pop       = 1'b0;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    sh_nxt    = mem[rd_ptr];
                    baud_nxt  = BAUD_TOP;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    baud_nxt  = BAUD_TOP;
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_nxt = BAUD_TOP;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            STOP: begin
                if (baud_cnt == '0) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        sh_nxt    = mem[rd_ptr];
                        baud_nxt  = BAUD_TOP;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        // The line level is decoded from the next state so tx itself is a clean flop output.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = sh_nxt[bit_nxt];
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: queue-and-frame-position model checked every cycle,
// a mid-bit line decoder, and hand-computed expectations for each scenario.
module tb_uart_tx_fifo;

    localparam int CLOCK_HZ  = 10_000;
    localparam int UART_BAUD = 1_000;
    localparam int DEPTH     = 16;
    localparam int DIV       = CLOCK_HZ / UART_BAUD;
    localparam int FRAME     = 10 * DIV;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       wr      = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_ovr = 1'b0;
    logic       tx;
    logic       full;
    logic       empty;
    logic       busy;
    logic [4:0] count;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_fifo #(
        .CLOCK_HZ (CLOCK_HZ),
        .UART_BAUD(UART_BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr),
        .wr_data(wr_data),
        .clr_ovr(clr_ovr),
        .tx     (tx),
        .full   (full),
        .empty  (empty),
        .busy   (busy),
        .count  (count),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endfunction

    // Model: bytes waiting, plus the frame on the line described by its byte and cycle offset.
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    logic [7:0] m_byte   = 8'h00;
    int         m_pos    = 0;
    bit         m_ovr    = 1'b0;
    int         m_pre;
    bit         m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovr    = 1'b0;
        end else begin
            m_pre = m_q.size();
            m_pop = 1'b0;
            if (!m_active) begin
                m_pop = (m_pre > 0);
            end else if (m_pos == FRAME - 1) begin
                if (m_pre > 0) m_pop = 1'b1;
                else m_active = 1'b0;
            end else begin
                m_pos++;
            end
            if (m_pop) begin
                m_byte   = m_q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
            if (wr && m_pre < DEPTH) m_q.push_back(wr_data);
            if (wr && m_pre == DEPTH) m_ovr = 1'b1;
            else if (clr_ovr) m_ovr = 1'b0;
        end
    end

    function automatic logic exp_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        check("tx",      int'(tx),      int'(exp_tx()));
        check("busy",    int'(busy),    int'(m_active));
        check("count",   int'(count),   m_q.size());
        check("empty",   int'(empty),   int'(m_q.size() == 0));
        check("full",    int'(full),    int'(m_q.size() == DEPTH));
        check("overrun", int'(overrun), int'(m_ovr));
    end

    // Mid-bit line decoder.
    logic [7:0] dec_q[$];
    logic [7:0] exp_q[$];
    bit         d_act = 1'b0;
    int         d_t   = 0;
    int         d_k;
    logic [7:0] d_byte;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            d_act = 1'b0;
            d_t   = 0;
            dec_q.delete();
        end else if (!d_act) begin
            if (tx == 1'b0) begin
                d_act = 1'b1;
                d_t   = 0;
            end
        end else begin
            d_t++;
            if (d_t % DIV == 5) begin
                d_k = d_t / DIV;
                if (d_k == 0) begin
                    check("start_bit", int'(tx), 0);
                end else if (d_k <= 8) begin
                    d_byte[d_k-1] = tx;
                end else begin
                    check("stop_bit", int'(tx), 1);
                    dec_q.push_back(d_byte);
                    d_act = 1'b0;
                end
            end
        end
    end

    task automatic check_dec(string name);
        check({name, "_frames"}, dec_q.size(), exp_q.size());
        for (int i = 0; i < dec_q.size() && i < exp_q.size(); i++) begin
            check({name, "_byte"}, int'(dec_q[i]), int'(exp_q[i]));
        end
        dec_q.delete();
        exp_q.delete();
    endtask

    // Sets the inputs for the next active edge.
    task automatic drive(input logic w, input logic [7:0] d, input logic c);
        @(negedge clk);
        wr      = w;
        wr_data = d;
        clr_ovr = c;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tx",      int'(tx),      1);
        check("rst_full",    int'(full),    0);
        check("rst_empty",   int'(empty),   1);
        check("rst_busy",    int'(busy),    0);
        check("rst_count",   int'(count),   0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte 0x41 written at edge 0.
        drive(1'b1, 8'h41, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("s1_e0_count", int'(count), 1);
        check("s1_e0_empty", int'(empty), 0);
        check("s1_e0_busy",  int'(busy),  0);
        @(negedge clk);
        check("s1_e1_count", int'(count), 0);
        check("s1_e1_busy",  int'(busy),  1);
        check("s1_e1_tx",    int'(tx),    0);
        repeat (14) @(negedge clk);
        check("s1_d0_tx", int'(tx), 1);
        repeat (10) @(negedge clk);
        check("s1_d1_tx", int'(tx), 0);
        repeat (75) @(negedge clk);
        check("s1_e100_tx",   int'(tx),   1);
        check("s1_e100_busy", int'(busy), 1);
        @(negedge clk);
        check("s1_e101_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        exp_q = '{8'h41};
        check_dec("single");

        // Back-to-back frames.
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'h0D, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        repeat (310) @(negedge clk);
        exp_q = '{8'h55, 8'hAA, 8'h0D};
        check_dec("b2b");

        // Overflow: bytes 0..17 on consecutive edges.
        for (int i = 0; i < 18; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("ovf_count",   int'(count),   16);
        check("ovf_full",    int'(full),    1);
        check("ovf_overrun", int'(overrun), 1);
        drive(1'b1, 8'hEE, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check("ovf_clr_vs_drop", int'(overrun), 1);
        drive(1'b0, 8'h00, 1'b0);
        check("ovf_clr",       int'(overrun), 0);
        check("ovf_count_hold", int'(count),  16);
        repeat (1750) @(negedge clk);
        for (int i = 0; i < 17; i++) exp_q.push_back(8'(i));
        check_dec("ovf");

        // Pushes landing exactly on pop edges while the pointers wrap.
        drive(1'b1, 8'h80, 1'b0);
        drive(1'b1, 8'h81, 1'b0);
        drive(1'b1, 8'h82, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("wrap_pre_count", int'(count), 2);
        for (int k = 0; k < 16; k++) begin
            repeat ((k == 0) ? 97 : 98) @(negedge clk);
            drive(1'b1, 8'(8'h83 + k), 1'b0);
            drive(1'b0, 8'h00, 1'b0);
            check("wrap_count", int'(count), 2);
        end
        repeat (320) @(negedge clk);
        for (int i = 0; i < 19; i++) exp_q.push_back(8'(8'h80 + i));
        check_dec("wrap");

        // Reset during data bit 3 with bytes still queued.
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        drive(1'b1, 8'h44, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        repeat (42) @(negedge clk);
        check("mid_busy",  int'(busy),  1);
        check("mid_tx",    int'(tx),    0);
        check("mid_count", int'(count), 3);
        #2 rst = 1'b1;
        #1;
        check("arst_tx",    int'(tx),    1);
        check("arst_count", int'(count), 0);
        check("arst_empty", int'(empty), 1);
        check("arst_busy",  int'(busy),  0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 8'h7E, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        repeat (120) @(negedge clk);
        exp_q = '{8'h7E};
        check_dec("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter for the MCU's `uart_tx` pin. It is the sending end of the serial link whose receiving end is `uart`'s RX path. The CPU-side store decode (address 0x006) pulses `wr` with a byte. The block queues bytes in a FIFO and shifts them out LSB-first at `UART_BAUD` with no inter-frame gap. It replaces the unbuffered TX path so that `printf`-style bursts do not stall the CPU.

## Interface
Parameters:
- `CLOCK_HZ`, default 27_000_000: clk frequency in Hz.
- `UART_BAUD`, default 115_200: bit rate. `DIV = CLOCK_HZ / UART_BAUD` (truncated) must be ≥ 2; elaboration error otherwise.
- `DEPTH`, default 16: FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `wr` in 1: enqueue strobe, one byte per cycle when high.
- `wr_data` in 8: byte to enqueue, sampled when `wr` is high.
- `clr_ovr` in 1: clears `overrun`.
- `tx` out 1: serial line; idle high.
- `full` out 1: FIFO count == `DEPTH`.
- `empty` out 1: FIFO count == 0. This does not include the byte in the shifter.
- `busy` out 1: shifter state ≠ IDLE.
- `count` out `$clog2(DEPTH)+1`: FIFO occupancy, 0..`DEPTH`.
- `overrun` out 1: sticky; set when a write is dropped.

## Operation
- FIFO: circular buffer with `DEPTH` entries, read/write pointers of `$clog2(DEPTH)` bits that wrap modulo `DEPTH`, and a separate `count` register.
- Write rules:
  - Accepted iff `wr` && !`full`, judged on the pre-edge `full`.
  - A write while `full` is dropped, even if a pop occurs in the same cycle. The dropped write sets `overrun`.
- Simultaneous accepted write and pop: `count` is unchanged and both pointers advance.
- `overrun` priority: set beats `clr_ovr` in the same cycle. `clr_ovr` alone clears it on the next edge.
- Shifter FSM:
  - IDLE: `tx`=1. If `count` ≠ 0, pop the head into `shreg[7:0]`, load `baud_cnt`=DIV-1, go to START.
  - START: `tx`=0 for DIV cycles, then DATA with `bit_idx`=0.
  - DATA: `tx`=`shreg[bit_idx]` for DIV cycles per bit. After bit 7 go to STOP.
  - STOP: `tx`=1 for DIV cycles. At its last cycle:
    - if `count` ≠ 0, pop and go directly to START (back-to-back frames, no idle cycle);
    - else go to IDLE.
- `baud_cnt` counts down from DIV-1. The bit period ends on the cycle `baud_cnt`==0; it then reloads to DIV-1.
- `tx` is a registered output and is glitch-free.
- Reset mid-frame: `tx` returns high immediately (async), the frame is aborted, and the FIFO is flushed. No partial frame resumes.

## Timing
- Reset values: `tx`=1, `full`=0, `empty`=1, `busy`=0, `count`=0, `overrun`=0. FSM is IDLE, pointers are 0.
- Write at edge N into an empty FIFO with the FSM in IDLE:
  - `count`=1 and `empty`=0 after edge N;
  - pop at edge N+1, so `count`=0, `busy`=1, `tx`=0 after edge N+1.
- Frame length is exactly 10×DIV cycles: start, d0..d7, stop.
- Back-to-back frames: start bit of frame k+1 begins at the edge ending the stop bit of frame k. Period is exactly 10×DIV.
- `busy` falls at the edge where STOP ends with the FIFO empty.
- Flags (`full`, `empty`, `count`, `overrun`) are registered and update on the same edge as the pointer change.

## Test plan
All scenarios use CLOCK_HZ=10_000, UART_BAUD=1_000 (DIV=10), DEPTH=16.
- Single byte: write 0x41 at edge 0.
  - `tx` low over cycles 1–10.
  - Then bits 1,0,0,0,0,0,1,0 at 10 cycles each.
  - Stop high over cycles 91–100.
  - `busy` falls at edge 101; a sampler at mid-bit decodes 0x41.
- Back-to-back: write 0x55, 0xAA, 0x0D on edges 0–2.
  - Three frames in 300 cycles with no idle high between stop and next start.
  - Decoded bytes in order 0x55, 0xAA, 0x0D.
- Overflow: write bytes 0..17 on 18 consecutive edges.
  - Byte 0 is in the shifter; bytes 1–16 are held, with `full`=1 and `count`=16.
  - Byte 17 is dropped and `overrun`=1.
  - The line then emits 0..16 in order.
  - `clr_ovr` pulse clears `overrun`; if `clr_ovr` coincides with another dropped write, `overrun` stays 1.
- Simultaneous push/pop at wrap-around:
  - Cycle the FIFO through more than 16 entries so the pointers wrap.
  - Write on the exact edge of a pop: `count` unchanged, no data loss or duplication across the wrap.
- Reset mid-frame: assert `rst` during DATA bit 3 of a frame with 4 bytes queued.
  - `tx`=1 asynchronously, and `count`=0, `empty`=1, `busy`=0.
  - After release, write 0x7E: one clean frame 0x7E, and none of the old bytes.
